// File: rtl/pc_unit_pkg.sv
// Shared types for the program-counter stage: FSM states, cause codes,
// default handler-byte addresses and the exception priority encoder.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_EXC_SAVE = 2'd1,
    ST_EXC_WAIT = 2'd2,
    ST_EXC_LOAD = 2'd3
  } pc_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_OPC  = 2'd1,
    CAUSE_OVF  = 2'd2,
    CAUSE_DIV0 = 2'd3
  } cause_e;

  localparam logic [31:0] DEF_VEC_OPCODE = 32'd253;
  localparam logic [31:0] DEF_VEC_OVF    = 32'd254;
  localparam logic [31:0] DEF_VEC_DIV0   = 32'd255;

  // Simultaneous requests resolve opcode > overflow > div0.
  function automatic cause_e exc_select(input logic opc, input logic ovf, input logic div0);
    cause_e c;
    c = CAUSE_NONE;
    if (opc)       c = CAUSE_OPC;
    else if (ovf)  c = CAUSE_OVF;
    else if (div0) c = CAUSE_DIV0;
    return c;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Bus between the control datapath and the PC stage.
// vec_rd is a fixed-latency request: the memory presents mem_vec_byte for
// vec_addr MEM_LAT cycles after vec_rd rises; there is no ready back-pressure.
interface pc_unit_if;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        branch_eq;
  logic        branch_ne;
  logic        alu_zero;
  logic        exc_opcode;
  logic        exc_overflow;
  logic        exc_div0;
  logic [7:0]  mem_vec_byte;
  logic [31:0] pc_q;
  logic [31:0] epc_q;
  logic [1:0]  cause_q;
  logic [31:0] vec_addr;
  logic        vec_rd;
  logic        busy;
  pc_unit_pkg::pc_state_e state_dbg;

  modport slave (
    input  pc_next, pc_write, branch_eq, branch_ne, alu_zero,
           exc_opcode, exc_overflow, exc_div0, mem_vec_byte,
    output pc_q, epc_q, cause_q, vec_addr, vec_rd, busy, state_dbg
  );

  modport master (
    output pc_next, pc_write, branch_eq, branch_ne, alu_zero,
           exc_opcode, exc_overflow, exc_div0, mem_vec_byte,
    input  pc_q, epc_q, cause_q, vec_addr, vec_rd, busy, state_dbg
  );
endinterface

// File: rtl/pc_unit_write_gate.sv
// PC write enable: unconditional load, or a branch whose condition matches
// the ALU zero flag.
module pc_unit_write_gate (
  input  logic pc_write_i,
  input  logic branch_eq_i,
  input  logic branch_ne_i,
  input  logic alu_zero_i,
  output logic pc_we_o
);
  assign pc_we_o = pc_write_i
                 | (branch_eq_i &  alu_zero_i)
                 | (branch_ne_i & ~alu_zero_i);
endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: PC/EPC/cause registers, gated PC writes and the
// exception-entry sequence (save EPC, fetch handler byte, load PC).
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EPC_OFFSET = 32'd4,
  parameter int          MEM_LAT    = 1,
  parameter logic [31:0] VEC_OPCODE = DEF_VEC_OPCODE,
  parameter logic [31:0] VEC_OVF    = DEF_VEC_OVF,
  parameter logic [31:0] VEC_DIV0   = DEF_VEC_DIV0
) (
  input logic      clk,
  input logic      reset,
  pc_unit_if.slave bus
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  pc_state_e          state_q;
  cause_e             code_q;
  cause_e             cause_q;
  logic [31:0]        pc_q;
  logic [31:0]        epc_q;
  logic [31:0]        vec_addr_q;
  logic               vec_rd_q;
  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;

  logic   pc_we;
  logic   exc_any;
  cause_e exc_code;

  function automatic logic [31:0] vec_for(input cause_e c);
    logic [31:0] a;
    case (c)
      CAUSE_OPC: a = VEC_OPCODE;
      CAUSE_OVF: a = VEC_OVF;
      default:   a = VEC_DIV0;
    endcase
    return a;
  endfunction

  pc_unit_write_gate u_write_gate (
    .pc_write_i  (bus.pc_write),
    .branch_eq_i (bus.branch_eq),
    .branch_ne_i (bus.branch_ne),
    .alu_zero_i  (bus.alu_zero),
    .pc_we_o     (pc_we)
  );

  assign exc_any  = bus.exc_opcode | bus.exc_overflow | bus.exc_div0;
  assign exc_code = exc_select(bus.exc_opcode, bus.exc_overflow, bus.exc_div0);

  // The handler-byte read is launched on entry to EXC_SAVE so the memory
  // latency overlaps the EPC save; vec_rd spans EXC_SAVE and EXC_WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      code_q     <= CAUSE_NONE;
      cause_q    <= CAUSE_NONE;
      pc_q       <= RESET_PC;
      epc_q      <= 32'h0;
      vec_addr_q <= 32'h0;
      vec_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (exc_any) begin
            state_q    <= ST_EXC_SAVE;
            busy_q     <= 1'b1;
            code_q     <= exc_code;
            vec_addr_q <= vec_for(exc_code);
            vec_rd_q   <= 1'b1;
          end else if (pc_we) begin
            pc_q <= bus.pc_next;
          end
        end
        ST_EXC_SAVE: begin
          epc_q   <= pc_q - EPC_OFFSET;
          cause_q <= code_q;
          cnt_q   <= CNT_W'(MEM_LAT - 1);
          state_q <= ST_EXC_WAIT;
        end
        ST_EXC_WAIT: begin
          if (cnt_q == '0) begin
            state_q  <= ST_EXC_LOAD;
            vec_rd_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_EXC_LOAD: begin
          pc_q    <= {24'b0, bus.mem_vec_byte};
          busy_q  <= 1'b0;
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign bus.pc_q      = pc_q;
  assign bus.epc_q     = epc_q;
  assign bus.cause_q   = cause_q;
  assign bus.vec_addr  = vec_addr_q;
  assign bus.vec_rd    = vec_rd_q;
  assign bus.busy      = busy_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: one instance with MEM_LAT=1, one with MEM_LAT=3.
module tb_pc_unit;
  import pc_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  pc_unit_if if_a ();
  pc_unit_if if_b ();

  pc_unit #(.MEM_LAT(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  pc_unit #(.MEM_LAT(3)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic clear_inputs();
    if_a.pc_next = '0; if_a.pc_write = 0; if_a.branch_eq = 0; if_a.branch_ne = 0;
    if_a.alu_zero = 0; if_a.exc_opcode = 0; if_a.exc_overflow = 0; if_a.exc_div0 = 0;
    if_a.mem_vec_byte = '0;
    if_b.pc_next = '0; if_b.pc_write = 0; if_b.branch_eq = 0; if_b.branch_ne = 0;
    if_b.alu_zero = 0; if_b.exc_opcode = 0; if_b.exc_overflow = 0; if_b.exc_div0 = 0;
    if_b.mem_vec_byte = '0;
  endtask

  task automatic wait_a(input int pulse_k, output int k_idle, output int rd_cnt,
                        output logic busy_k1, output logic [31:0] pc_k1);
    k_idle = 0; rd_cnt = 0; busy_k1 = 0; pc_k1 = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if_a.exc_opcode = 0; if_a.exc_overflow = 0; if_a.pc_write = 0;
        busy_k1 = if_a.busy; pc_k1 = if_a.pc_q;
      end
      if_a.exc_div0 = (pulse_k != 0 && k == pulse_k);
      if (if_a.vec_rd) rd_cnt++;
      if (!if_a.busy) begin k_idle = k; break; end
    end
    if_a.exc_div0 = 0;
  endtask

  task automatic wait_b(output int k_idle, output int rd_cnt);
    k_idle = 0; rd_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin if_b.exc_opcode = 0; if_b.exc_overflow = 0; if_b.exc_div0 = 0; end
      if (if_b.vec_rd) rd_cnt++;
      if (!if_b.busy) begin k_idle = k; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    total++; if (if_a.pc_q !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", if_a.pc_q, 32'h0); end
    total++; if (if_a.epc_q !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h exp=%h", if_a.epc_q, 32'h0); end
    total++; if (if_a.cause_q !== 2'd0) begin bad++; $display("FAIL reset_cause got=%0d exp=0", if_a.cause_q); end
    total++; if (if_a.vec_addr !== 32'h0) begin bad++; $display("FAIL reset_vec_addr got=%h exp=0", if_a.vec_addr); end
    total++; if ({if_a.vec_rd, if_a.busy} !== 2'b00) begin bad++; $display("FAIL reset_rd_busy got=%b exp=00", {if_a.vec_rd, if_a.busy}); end
    total++; if ({if_b.pc_q, if_b.busy} !== 33'h0) begin bad++; $display("FAIL reset_b got=%h exp=0", {if_b.pc_q, if_b.busy}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_branches();
    logic [31:0] cur_pc;
    logic [31:0] pcn [6];
    logic        beq [6];
    logic        bne [6];
    logic        z   [6];
    if_a.pc_next = 32'h10; if_a.pc_write = 1; exp_q.push_back(32'h10);
    @(negedge clk); if_a.pc_write = 0;
    exp_v = exp_q.pop_front();
    total++; if (if_a.pc_q !== exp_v) begin bad++; $display("FAIL br_load got=%h exp=%h", if_a.pc_q, exp_v); end
    cur_pc = 32'h10;
    pcn[0] = 32'h40; beq[0] = 1; bne[0] = 0; z[0] = 0;
    pcn[1] = 32'h40; beq[1] = 1; bne[1] = 0; z[1] = 1;
    pcn[2] = 32'h80; beq[2] = 0; bne[2] = 1; z[2] = 0;
    pcn[3] = 32'h90; beq[3] = 0; bne[3] = 1; z[3] = 1;
    for (int i = 4; i < 6; i++) begin
      pcn[i] = $urandom; beq[i] = 1'($urandom_range(0, 1));
      bne[i] = 1'($urandom_range(0, 1)); z[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 6; i++) begin
      if_a.pc_next = pcn[i]; if_a.branch_eq = beq[i]; if_a.branch_ne = bne[i]; if_a.alu_zero = z[i];
      if ((beq[i] && z[i]) || (bne[i] && !z[i])) cur_pc = pcn[i];
      exp_q.push_back(cur_pc);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      total++; if (if_a.pc_q !== exp_v) begin bad++; $display("FAIL br_case%0d got=%h exp=%h", i, if_a.pc_q, exp_v); end
    end
    if_a.branch_eq = 0; if_a.branch_ne = 0; if_a.alu_zero = 0;
  endtask

  task automatic test_overflow();
    int k_idle, rd_cnt; logic busy_k1; logic [31:0] pc_k1;
    if_a.pc_next = 32'h1C; if_a.pc_write = 1;
    @(negedge clk);
    if_a.exc_overflow = 1; if_a.pc_write = 1; if_a.pc_next = 32'h99; if_a.mem_vec_byte = 8'h7A;
    exp_q.push_back(32'h7A);
    wait_a(0, k_idle, rd_cnt, busy_k1, pc_k1);
    total++; if (pc_k1 !== 32'h1C) begin bad++; $display("FAIL ovf_no_write got=%h exp=%h", pc_k1, 32'h1C); end
    total++; if (busy_k1 !== 1'b1) begin bad++; $display("FAIL ovf_busy_rise got=%b exp=1", busy_k1); end
    total++; if (k_idle != 4) begin bad++; $display("FAIL ovf_latency got=%0d exp=4", k_idle); end
    total++; if (rd_cnt != 2) begin bad++; $display("FAIL ovf_vec_rd_cycles got=%0d exp=2", rd_cnt); end
    exp_v = exp_q.pop_front();
    total++; if (if_a.pc_q !== exp_v) begin bad++; $display("FAIL ovf_handler_pc got=%h exp=%h", if_a.pc_q, exp_v); end
    total++; if (if_a.epc_q !== 32'h18) begin bad++; $display("FAIL ovf_epc got=%h exp=%h", if_a.epc_q, 32'h18); end
    total++; if (if_a.cause_q !== 2'd2) begin bad++; $display("FAIL ovf_cause got=%0d exp=2", if_a.cause_q); end
    total++; if (if_a.vec_addr !== 32'd254) begin bad++; $display("FAIL ovf_vec_addr got=%0d exp=254", if_a.vec_addr); end
  endtask

  task automatic test_priority();
    int k_idle, rd_cnt; logic busy_k1; logic [31:0] pc_k1;
    if_a.exc_opcode = 1; if_a.exc_div0 = 1; if_a.mem_vec_byte = 8'h33;
    exp_q.push_back(32'h33);
    wait_a(2, k_idle, rd_cnt, busy_k1, pc_k1);
    total++; if (k_idle != 4) begin bad++; $display("FAIL prio_latency got=%0d exp=4", k_idle); end
    total++; if (if_a.cause_q !== 2'd1) begin bad++; $display("FAIL prio_cause got=%0d exp=1", if_a.cause_q); end
    total++; if (if_a.vec_addr !== 32'd253) begin bad++; $display("FAIL prio_vec_addr got=%0d exp=253", if_a.vec_addr); end
    total++; if (if_a.epc_q !== 32'h76) begin bad++; $display("FAIL prio_epc got=%h exp=%h", if_a.epc_q, 32'h76); end
    exp_v = exp_q.pop_front();
    total++; if (if_a.pc_q !== exp_v) begin bad++; $display("FAIL prio_handler_pc got=%h exp=%h", if_a.pc_q, exp_v); end
    repeat (2) @(negedge clk);
    total++; if ({if_a.busy, if_a.cause_q} !== 3'b001) begin bad++; $display("FAIL prio_no_queue got=%b exp=001", {if_a.busy, if_a.cause_q}); end
  endtask

  task automatic test_wrap_latency();
    int k_idle, rd_cnt;
    if_b.exc_div0 = 1; if_b.mem_vec_byte = 8'h5C;
    exp_q.push_back(32'h5C);
    wait_b(k_idle, rd_cnt);
    total++; if (if_b.epc_q !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_epc got=%h exp=%h", if_b.epc_q, 32'hFFFF_FFFC); end
    total++; if (if_b.vec_addr !== 32'd255) begin bad++; $display("FAIL wrap_vec_addr got=%0d exp=255", if_b.vec_addr); end
    total++; if (rd_cnt != 4) begin bad++; $display("FAIL wrap_vec_rd_cycles got=%0d exp=4", rd_cnt); end
    total++; if (k_idle != 6) begin bad++; $display("FAIL wrap_latency got=%0d exp=6", k_idle); end
    exp_v = exp_q.pop_front();
    total++; if (if_b.pc_q !== exp_v) begin bad++; $display("FAIL wrap_handler_pc got=%h exp=%h", if_b.pc_q, exp_v); end
    total++; if (if_b.cause_q !== 2'd3) begin bad++; $display("FAIL wrap_cause got=%0d exp=3", if_b.cause_q); end
  endtask

  task automatic test_return();
    if_a.pc_next = 32'h76; if_a.pc_write = 1; exp_q.push_back(32'h76);
    @(negedge clk); if_a.pc_write = 0;
    exp_v = exp_q.pop_front();
    total++; if (if_a.pc_q !== exp_v) begin bad++; $display("FAIL ret_pc got=%h exp=%h", if_a.pc_q, exp_v); end
    if_a.pc_next = 32'h200; if_a.branch_ne = 1; if_a.alu_zero = 0; exp_q.push_back(32'h200);
    @(negedge clk); if_a.branch_ne = 0;
    exp_v = exp_q.pop_front();
    total++; if (if_a.pc_q !== exp_v) begin bad++; $display("FAIL ret_branch got=%h exp=%h", if_a.pc_q, exp_v); end
    total++; if (if_a.epc_q !== 32'h76) begin bad++; $display("FAIL ret_epc_hold got=%h exp=%h", if_a.epc_q, 32'h76); end
    total++; if (if_a.cause_q !== 2'd1) begin bad++; $display("FAIL ret_cause_hold got=%0d exp=1", if_a.cause_q); end
  endtask

  task automatic test_reset_mid();
    logic reached;
    reached = 0;
    if_b.exc_opcode = 1; if_b.mem_vec_byte = 8'hEE;
    @(negedge clk); if_b.exc_opcode = 0;
    for (int k = 0; k < 10; k++) begin
      if (if_b.state_dbg == ST_EXC_WAIT) begin reached = 1; break; end
      @(negedge clk);
    end
    total++; if (reached !== 1'b1) begin bad++; $display("FAIL mid_reach_wait got=%b exp=1", reached); end
    reset = 1'b1;
    #1;
    total++; if (if_b.pc_q !== 32'h0) begin bad++; $display("FAIL mid_reset_pc got=%h exp=0", if_b.pc_q); end
    total++; if (if_b.epc_q !== 32'h0) begin bad++; $display("FAIL mid_reset_epc got=%h exp=0", if_b.epc_q); end
    total++; if (if_b.cause_q !== 2'd0) begin bad++; $display("FAIL mid_reset_cause got=%0d exp=0", if_b.cause_q); end
    total++; if ({if_b.busy, if_b.vec_rd} !== 2'b00) begin bad++; $display("FAIL mid_reset_busy got=%b exp=00", {if_b.busy, if_b.vec_rd}); end
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({if_b.busy, if_b.pc_q} !== 33'h0) begin bad++; $display("FAIL mid_reset_lost got=%h exp=0", {if_b.busy, if_b.pc_q}); end
  endtask

  // sequence + final report
  initial begin
    test_reset();
    test_branches();
    test_overflow();
    test_priority();
    test_wrap_latency();
    test_return();
    test_reset_mid();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
